// File: rtl/p256_operand_port.sv
// p256_operand_port: word-serial operand/result port for a P-256 arithmetic engine.
// Holds a 256-bit operand and serves it 32 bits at a time with one-cycle read
// latency. Collects 32-bit result writes into a 256-bit result register. Drives
// the engine ena/rdy handshake so a controller sees a single start/done interface.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start, operand     controller request and 256-bit operand (latched in IDLE)
//   busy, done, err    controller status; err is valid only while done=1
//   result             collected result words, stable from DONE until next start
//   ena, rdy           engine enable / engine completion level
//   a_addr, a_din      engine operand read port (registered, one-cycle latency)
//   d_addr, d_wren,
//   d_dout             engine result write port
module p256_operand_port #(
    parameter int unsigned WORDS   = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [32*WORDS-1:0]      operand,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [32*WORDS-1:0]      result,
    output logic                     ena,
    input  logic                     rdy,
    input  logic [$clog2(WORDS)-1:0] a_addr,
    output logic [31:0]              a_din,
    input  logic [$clog2(WORDS)-1:0] d_addr,
    input  logic                     d_wren,
    input  logic [31:0]              d_dout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [WORDS-1:0][31:0] operand_q, operand_d;
    logic [WORDS-1:0][31:0] result_q, result_d;
    logic [WORDS-1:0]       mask_q, mask_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rdy_q, rdy_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   ena_q, ena_d;
    logic [31:0]            a_din_q, a_din_d;

    logic rdy_rise;
    logic at_limit;

    // Completion is a fresh rising edge only; a level already high is ignored.
    assign rdy_rise = rdy & ~rdy_q;
    assign at_limit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        result_d  = result_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        rdy_d     = rdy;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ena_d     = 1'b0;
        // Read decode is independent of state.
        a_din_d   = operand_q[a_addr];

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    operand_d = operand;
                    result_d  = '0;
                    mask_d    = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    ena_d     = 1'b1;
                    state_d   = ST_RUN;
                end
            end

            ST_RUN: begin
                busy_d = 1'b1;
                ena_d  = 1'b1;
                if (d_wren) begin
                    result_d[d_addr] = d_dout;
                    mask_d[d_addr]   = 1'b1;
                end
                // A write coinciding with the rdy edge is included in err.
                if (rdy_rise) begin
                    ena_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = (mask_d != '1);
                    state_d = ST_DONE;
                end else if (at_limit) begin
                    ena_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            operand_q <= '0;
            result_q  <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ena_q     <= 1'b0;
            a_din_q   <= '0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ena_q     <= ena_d;
            a_din_q   <= a_din_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign ena    = ena_q;
    assign result = result_q;
    assign a_din  = a_din_q;

endmodule
